// File: rtl/fir_host_cfg.sv
// AXI-Lite initiator that programs, verifies and launches the fir accelerator,
// then polls ap_done until completion or timeout.
module fir_host_cfg #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int POLL_GAP    = 8,
   parameter int POLL_MAX    = 65535
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   input  logic [pDATA_WIDTH-1:0] data_len,
   input  logic [5:0]             tap_num,
   output logic [4:0]             coef_addr,
   input  logic [pDATA_WIDTH-1:0] coef_data,
   output logic                   awvalid,
   output logic [pADDR_WIDTH-1:0] awaddr,
   input  logic                   awready,
   output logic                   wvalid,
   output logic [pDATA_WIDTH-1:0] wdata,
   input  logic                   wready,
   output logic                   arvalid,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   arready,
   output logic                   rready,
   input  logic                   rvalid,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   busy,
   output logic                   done,
   output logic                   cfg_err,
   output logic                   timeout,
   output logic [5:0]             mismatch_cnt
);

   localparam int PW = $clog2(POLL_MAX + 1);

   typedef enum logic [3:0] {
      IDLE, WR_LEN, WR_TAPN, FETCH, WR_COEF, RD_COEF,
      CHECK, WR_START, POLL_WAIT, POLL_RD, FIN
   } state_t;

   state_t                 state_q, state_d;
   logic [5:0]             k_q, k_d, ntap_q, ntap_d, mis_q, mis_d;
   logic                   rdph_q, rdph_d, fwait_q, fwait_d;
   logic [7:0]             gap_q, gap_d;
   logic [PW-1:0]          poll_q, poll_d;
   logic                   err_q, err_d, to_q, to_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [4:0]             caddr_q, caddr_d;
   logic                   awv_q, awv_d, wv_q, wv_d, arv_q, arv_d, rr_q, rr_d;
   logic [pADDR_WIDTH-1:0] awa_q, awa_d, ara_q, ara_d, coef_a;
   logic [pDATA_WIDTH-1:0] wd_q, wd_d, rdat_q, rdat_d;
   logic                   wr_idle, rd_idle;

   assign coef_a  = pADDR_WIDTH'(12'h080) + pADDR_WIDTH'({k_q[4:0], 2'b00});
   assign wr_idle = !awv_q && !wv_q;
   assign rd_idle = !arv_q && !rr_q;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         ntap_q  <= '0;
         mis_q   <= '0;
         rdph_q  <= 1'b0;
         fwait_q <= 1'b0;
         gap_q   <= '0;
         poll_q  <= '0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         caddr_q <= '0;
         awv_q   <= 1'b0;
         wv_q    <= 1'b0;
         arv_q   <= 1'b0;
         rr_q    <= 1'b0;
         awa_q   <= '0;
         ara_q   <= '0;
         wd_q    <= '0;
         rdat_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ntap_q  <= ntap_d;
         mis_q   <= mis_d;
         rdph_q  <= rdph_d;
         fwait_q <= fwait_d;
         gap_q   <= gap_d;
         poll_q  <= poll_d;
         err_q   <= err_d;
         to_q    <= to_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         caddr_q <= caddr_d;
         awv_q   <= awv_d;
         wv_q    <= wv_d;
         arv_q   <= arv_d;
         rr_q    <= rr_d;
         awa_q   <= awa_d;
         ara_q   <= ara_d;
         wd_q    <= wd_d;
         rdat_q  <= rdat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      ntap_d  = ntap_q;
      mis_d   = mis_q;
      rdph_d  = rdph_q;
      fwait_d = fwait_q;
      gap_d   = gap_q;
      poll_d  = poll_q;
      err_d   = err_q;
      to_d    = to_q;
      caddr_d = caddr_q;
      awv_d   = awv_q;
      wv_d    = wv_q;
      arv_d   = arv_q;
      rr_d    = rr_q;
      awa_d   = awa_q;
      ara_d   = ara_q;
      wd_d    = wd_q;
      rdat_d  = rdat_q;
      // each channel retires on its own handshake
      if (awv_q && awready) begin
         awv_d = 1'b0;
         awa_d = '0;
      end
      if (wv_q && wready) begin
         wv_d = 1'b0;
         wd_d = '0;
      end
      if (arv_q && arready) begin
         arv_d = 1'b0;
         ara_d = '0;
      end
      if (rr_q && rvalid) begin
         rr_d   = 1'b0;
         rdat_d = rdata;
      end
      unique case (state_q)
         IDLE: if (start) begin
            state_d = WR_LEN;
            ntap_d  = (tap_num > 6'd32) ? 6'd32 : tap_num;
            mis_d   = '0;
            err_d   = 1'b0;
            to_d    = 1'b0;
         end
         WR_LEN: if (wr_idle) state_d = WR_TAPN;
         WR_TAPN: if (wr_idle) begin
            k_d     = '0;
            rdph_d  = 1'b0;
            state_d = (ntap_q == 6'd0) ? WR_START : FETCH;
         end
         // two cycles: ROM address settles, then ROM data is valid
         FETCH: begin
            fwait_d = 1'b1;
            if (fwait_q) begin
               fwait_d = 1'b0;
               state_d = rdph_q ? RD_COEF : WR_COEF;
            end
         end
         WR_COEF: if (wr_idle) begin
            state_d = FETCH;
            if (k_q + 6'd1 == ntap_q) begin
               k_d    = '0;
               rdph_d = 1'b1;
            end else begin
               k_d = k_q + 6'd1;
            end
         end
         RD_COEF: if (rd_idle) state_d = CHECK;
         CHECK: begin
            if (rdat_q != coef_data && mis_q != 6'd32)
               mis_d = mis_q + 6'd1;
            if (k_q + 6'd1 == ntap_q) begin
               if (mis_d != 6'd0) begin
                  err_d   = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = WR_START;
               end
            end else begin
               k_d     = k_q + 6'd1;
               state_d = FETCH;
            end
         end
         WR_START: if (wr_idle) begin
            gap_d   = '0;
            poll_d  = '0;
            state_d = POLL_WAIT;
         end
         POLL_WAIT: begin
            if (gap_q == 8'(POLL_GAP - 1)) state_d = POLL_RD;
            else gap_d = gap_q + 8'd1;
         end
         POLL_RD: if (rd_idle) begin
            if (rdat_q[1]) begin
               state_d = FIN;
            end else if (poll_q + 1'b1 == PW'(POLL_MAX)) begin
               to_d    = 1'b1;
               state_d = FIN;
            end else begin
               poll_d  = poll_q + 1'b1;
               gap_d   = '0;
               state_d = POLL_WAIT;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // bus launches happen on the edge that enters the state
      if (state_d != state_q) begin
         unique case (state_d)
            WR_LEN: begin
               awv_d = 1'b1; wv_d = 1'b1;
               awa_d = pADDR_WIDTH'(12'h010);
               wd_d  = data_len;
            end
            WR_TAPN: begin
               awv_d = 1'b1; wv_d = 1'b1;
               awa_d = pADDR_WIDTH'(12'h014);
               wd_d  = pDATA_WIDTH'(ntap_q);
            end
            WR_COEF: begin
               awv_d = 1'b1; wv_d = 1'b1;
               awa_d = coef_a;
               wd_d  = coef_data;
            end
            WR_START: begin
               awv_d = 1'b1; wv_d = 1'b1;
               awa_d = '0;
               wd_d  = pDATA_WIDTH'(1);
            end
            RD_COEF: begin
               arv_d = 1'b1; rr_d = 1'b1;
               ara_d = coef_a;
            end
            POLL_RD: begin
               arv_d = 1'b1; rr_d = 1'b1;
               ara_d = '0;
            end
            FETCH:   caddr_d = k_d[4:0];
            default: ;
         endcase
      end
      busy_d = (state_d != IDLE) && (state_d != FIN);
      done_d = (state_d == FIN);
   end

   assign coef_addr    = caddr_q;
   assign awvalid      = awv_q;
   assign awaddr       = awa_q;
   assign wvalid       = wv_q;
   assign wdata        = wd_q;
   assign arvalid      = arv_q;
   assign araddr       = ara_q;
   assign rready       = rr_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign cfg_err      = err_q;
   assign timeout      = to_q;
   assign mismatch_cnt = mis_q;

endmodule

// File: tb/tb_fir_host_cfg.sv
// Bench for fir_host_cfg: AXI-Lite responder with delays, coefficient ROM,
// transaction log checked against a sequence-level model.
module tb_fir_host_cfg;

   localparam int PGAP = 2;
   localparam int PMAX = 4;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] data_len = '0;
   logic [5:0]  tap_num = '0;
   logic [4:0]  coef_addr;
   logic [31:0] coef_data = '0;
   logic        awvalid, wvalid, arvalid, rready;
   logic [11:0] awaddr, araddr;
   logic [31:0] wdata;
   logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        busy, done, cfg_err, timeout;
   logic [5:0]  mismatch_cnt;

   fir_host_cfg #(
      .pADDR_WIDTH(12), .pDATA_WIDTH(32),
      .POLL_GAP(PGAP), .POLL_MAX(PMAX)
   ) dut (
      .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start),
      .data_len(data_len), .tap_num(tap_num),
      .coef_addr(coef_addr), .coef_data(coef_data),
      .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wready(wready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rready(rready), .rvalid(rvalid), .rdata(rdata),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .timeout(timeout), .mismatch_cnt(mismatch_cnt)
   );

   always #5 axis_clk = ~axis_clk;

   typedef struct packed {
      logic        rd;
      logic [11:0] a;
      logic [31:0] d;
   } txn_t;

   typedef struct {
      logic [31:0] len;
      int          tap;
      logic [31:0] corrupt;
      int          done_after;
      int          awd, wd, ard, rd;
      int          exp_mis;
      bit          exp_err;
      bit          exp_to;
   } vec_t;

   int checks = 0;
   int failures = 0;

   logic [31:0] rom [32];
   logic [31:0] mem [32];
   txn_t        log_q[$];
   logic [11:0] aw_q[$];
   logic [31:0] w_q[$];

   int aw_dly, w_dly, ar_dly, r_dly, done_after;
   logic [31:0] corrupt;
   int aw_cnt, w_cnt, ar_cnt, r_wait, polls, proto_err, done_cnt;
   bit r_pend, p_awv, p_wv, p_arv;
   logic [31:0] r_val;

   always @(posedge axis_clk) coef_data <= rom[coef_addr];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // responder: decisions made on the falling edge, seen by the DUT next rise
   always @(negedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = '0;
         aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_pend = 0;
         p_awv = 0; p_wv = 0; p_arv = 0;
         aw_q.delete(); w_q.delete();
      end else begin
         if (awready && awvalid) proto_err++;
         if (wready && wvalid) proto_err++;
         if (arready && arvalid) proto_err++;
         if (rvalid && rready) proto_err++;
         if (p_awv && !awready && !awvalid) proto_err++;
         if (p_wv && !wready && !wvalid) proto_err++;
         if (p_arv && !arready && !arvalid) proto_err++;
         if (awvalid && !p_awv && !wvalid) proto_err++;
         if (wvalid && !p_wv && !awvalid) proto_err++;
         if (!awvalid && awaddr != 0) proto_err++;
         if (!wvalid && wdata != 0) proto_err++;
         rvalid = 0;
         if (r_pend) begin
            if (r_wait == 0) begin
               rvalid = 1; rdata = r_val; r_pend = 0;
               if (!rready) proto_err++;
            end else r_wait--;
         end
         if (awvalid && !awready) begin
            if (aw_cnt >= aw_dly) begin
               awready = 1; aw_q.push_back(awaddr);
            end else aw_cnt++;
         end else begin awready = 0; aw_cnt = 0; end
         if (wvalid && !wready) begin
            if (w_cnt >= w_dly) begin
               wready = 1; w_q.push_back(wdata);
            end else w_cnt++;
         end else begin wready = 0; w_cnt = 0; end
         if (arvalid && !arready) begin
            if (ar_cnt >= ar_dly) begin
               arready = 1;
               log_q.push_back('{1'b1, araddr, 32'h0});
               if (araddr == 12'h000) begin
                  polls++;
                  r_val = (done_after != 0 && polls >= done_after) ? 32'h2 : 32'h0;
               end else begin
                  r_val = mem[araddr[6:2]] ^ {31'h0, corrupt[araddr[6:2]]};
               end
               if (r_dly == 0) begin
                  rvalid = 1; rdata = r_val;
                  if (!rready) proto_err++;
               end else begin
                  r_pend = 1; r_wait = r_dly - 1;
               end
            end else ar_cnt++;
         end else begin arready = 0; ar_cnt = 0; end
         while (aw_q.size() > 0 && w_q.size() > 0) begin
            logic [11:0] a;
            logic [31:0] d;
            a = aw_q.pop_front();
            d = w_q.pop_front();
            log_q.push_back('{1'b0, a, d});
            if (a >= 12'h080) mem[a[6:2]] = d;
         end
         p_awv = awvalid; p_wv = wvalid; p_arv = arvalid;
      end
   end

   always @(negedge axis_clk) if (done) done_cnt++;

   function automatic int clamp_n(int t);
      return (t > 32) ? 32 : t;
   endfunction

   function automatic vec_t fill_exp(vec_t v);
      int n;
      n = clamp_n(v.tap);
      v.exp_mis = 0;
      for (int k = 0; k < n; k++) if (v.corrupt[k]) v.exp_mis++;
      v.exp_err = (v.exp_mis != 0);
      v.exp_to  = !v.exp_err && !(v.done_after >= 1 && v.done_after <= PMAX);
      return v;
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      txn_t exp_q[$];
      int   n, np, cyc;
      bit   mis_any;
      n = clamp_n(v.tap);
      exp_q.push_back('{1'b0, 12'h010, v.len});
      exp_q.push_back('{1'b0, 12'h014, 32'(n)});
      for (int k = 0; k < n; k++)
         exp_q.push_back('{1'b0, 12'h080 + 12'(4 * k), rom[k]});
      for (int k = 0; k < n; k++)
         exp_q.push_back('{1'b1, 12'h080 + 12'(4 * k), 32'h0});
      mis_any = 0;
      for (int k = 0; k < n; k++) if (v.corrupt[k]) mis_any = 1;
      if (!mis_any) begin
         exp_q.push_back('{1'b0, 12'h000, 32'h1});
         np = (v.done_after >= 1 && v.done_after <= PMAX) ? v.done_after : PMAX;
         for (int p = 0; p < np; p++) exp_q.push_back('{1'b1, 12'h000, 32'h0});
      end
      aw_dly = v.awd; w_dly = v.wd; ar_dly = v.ard; r_dly = v.rd;
      corrupt = v.corrupt; done_after = v.done_after; polls = 0;
      log_q.delete(); proto_err = 0; done_cnt = 0;
      @(negedge axis_clk);
      data_len = v.len; tap_num = 6'(v.tap); start = 1;
      @(negedge axis_clk);
      start = 0; data_len = 32'hffff_ffff; tap_num = 6'd7;
      chk({tag, " launch"},
          {39'h0, busy, awvalid, wvalid, awaddr, cfg_err, timeout, mismatch_cnt},
          {39'h0, 1'b1, 1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 6'd0});
      repeat (3) @(negedge axis_clk);
      start = 1; data_len = 32'hdead;
      @(negedge axis_clk);
      start = 0;
      cyc = 0;
      while (!done && cyc < 4000) begin
         @(negedge axis_clk);
         cyc++;
      end
      chk({tag, " done_seen"}, 64'(done), 64'h1);
      start = 1;
      @(negedge axis_clk);
      start = 0;
      chk({tag, " start_at_done"}, {61'h0, busy, awvalid, arvalid}, 64'h0);
      repeat (3) @(negedge axis_clk);
      chk({tag, " done_pulses"}, 64'(done_cnt), 64'h1);
      chk({tag, " protocol"}, 64'(proto_err), 64'h0);
      chk({tag, " mismatch_cnt"}, 64'(mismatch_cnt), 64'(v.exp_mis));
      chk({tag, " cfg_err"}, 64'(cfg_err), 64'(v.exp_err));
      chk({tag, " timeout"}, 64'(timeout), 64'(v.exp_to));
      chk({tag, " txn_count"}, 64'(log_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
         chk($sformatf("%s txn%0d", tag, i), 64'(log_q[i]), 64'(exp_q[i]));
   endtask

   vec_t tbl [6];

   initial begin
      vec_t v;
      int   cyc;
      #2000000;
      $display("FAIL watchdog: got no end expected end");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   cyc;
      tbl[0] = '{400, 32, 32'h0, 3, 0, 0, 0, 0, 0, 0, 0};
      tbl[1] = '{400, 32, 32'h1000_0002, 3, 0, 0, 0, 0, 2, 1, 0};
      tbl[2] = '{400, 32, 32'h0, 3, 3, 0, 0, 2, 0, 0, 0};
      tbl[3] = '{77, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[4] = '{5, 40, 32'h0, 2, 1, 2, 1, 1, 0, 0, 0};
      tbl[5] = '{9, 5, 32'h0, 0, 0, 0, 0, 0, 0, 0, 1};
      for (int k = 0; k < 32; k++) begin
         rom[k] = 32'(k + 1);
         mem[k] = '0;
      end
      #1;
      chk("reset_state",
          {awvalid, wvalid, arvalid, rready, awaddr, araddr, wdata[7:0],
           coef_addr, busy, done, cfg_err, timeout, mismatch_cnt},
          '0);
      repeat (3) @(negedge axis_clk);
      axis_rst_n = 1;
      for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // reset while the 5th coefficient write is waiting on awready
      v = tbl[2];
      aw_dly = 3; w_dly = 0; ar_dly = 0; r_dly = 0;
      corrupt = 0; done_after = 3; polls = 0;
      @(negedge axis_clk);
      data_len = 400; tap_num = 32; start = 1;
      @(negedge axis_clk);
      start = 0;
      cyc = 0;
      while (!(awvalid && awaddr == 12'h090) && cyc < 2000) begin
         @(negedge axis_clk);
         cyc++;
      end
      chk("rst_reach_5th", 64'(awaddr), 64'h090);
      axis_rst_n = 0;
      #1;
      chk("rst_async_clear",
          {23'h0, awvalid, wvalid, arvalid, rready, awaddr, araddr, coef_addr,
           busy, done, cfg_err, timeout, mismatch_cnt},
          64'h0);
      chk("rst_wdata", 64'(wdata), 64'h0);
      @(negedge axis_clk);
      axis_rst_n = 1;
      run_vec(tbl[0], "after_rst");

      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < 32; k++) rom[k] = $urandom;
         v.len = $urandom;
         v.tap = $urandom_range(0, 40);
         v.corrupt = ($urandom_range(0, 2) == 0) ?
                     ($urandom & $urandom & $urandom) : 32'h0;
         v.done_after = $urandom_range(0, 5);
         v.awd = $urandom_range(0, 3);
         v.wd  = $urandom_range(0, 3);
         v.ard = $urandom_range(0, 3);
         v.rd  = $urandom_range(0, 3);
         v = fill_exp(v);
         run_vec(v, $sformatf("rnd%0d", r));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
